// File: rtl/regdesp_pkg.sv
// ----------------------------------------------------------------------------
// regdesp_pkg
//   Shared encodings for the universal shift register (registro_desplazable).
//   MODO_* : operation select values driven on the MODO port.
//   DIR_*  : shift/rotate direction values driven on the DIR port.
// ----------------------------------------------------------------------------
package regdesp_pkg;

    localparam logic [1:0] MODO_SHIFT = 2'b00;
    localparam logic [1:0] MODO_ROT   = 2'b01;
    localparam logic [1:0] MODO_LOAD  = 2'b10;
    localparam logic [1:0] MODO_HOLD  = 2'b11;

    localparam logic DIR_LEFT  = 1'b0;  // toward MSB
    localparam logic DIR_RIGHT = 1'b1;  // toward LSB

endpackage : regdesp_pkg

// File: rtl/regdesp_next.sv
// ----------------------------------------------------------------------------
// regdesp_next
//   Purely combinational next-state logic for the universal shift register.
//   Given the current contents and the operation controls, it produces the
//   value Q and S_OUT take on the next enabled clock edge.
//
// Ports
//   q          in   WIDTH  current register contents
//   s_out      in   1      current serial output (kept on HOLD)
//   d          in   WIDTH  parallel load data
//   s_in       in   1      serial input bit
//   dir        in   1      0 = left (toward MSB), 1 = right (toward LSB)
//   modo       in   2      operation select
//   q_next     out  WIDTH  next register contents
//   s_out_next out  1      next serial output bit
// ----------------------------------------------------------------------------
module regdesp_next
    import regdesp_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] q,
    input  logic             s_out,
    input  logic [WIDTH-1:0] d,
    input  logic             s_in,
    input  logic             dir,
    input  logic [1:0]       modo,
    output logic [WIDTH-1:0] q_next,
    output logic             s_out_next
);

    always_comb begin
        // NOTE: both outputs get a default before the case so every path
        // assigns them; a missing assignment here would infer a latch.
        q_next     = q;
        s_out_next = s_out;

        unique case (modo)
            MODO_SHIFT: begin
                if (dir == DIR_LEFT) begin
                    q_next     = {q[WIDTH-2:0], s_in};
                    s_out_next = q[WIDTH-1];
                end else begin
                    q_next     = {s_in, q[WIDTH-1:1]};
                    s_out_next = q[0];
                end
            end
            MODO_ROT: begin
                if (dir == DIR_LEFT) begin
                    q_next = {q[WIDTH-2:0], q[WIDTH-1]};
                end else begin
                    q_next = {q[0], q[WIDTH-1:1]};
                end
                s_out_next = 1'b0;
            end
            MODO_LOAD: begin
                q_next     = d;
                s_out_next = 1'b0;
            end
            MODO_HOLD: begin
                q_next     = q;
                s_out_next = s_out;
            end
            default: begin
                // Unknown select values hold state rather than propagate X.
                q_next     = q;
                s_out_next = s_out;
            end
        endcase
    end

endmodule : regdesp_next

// File: rtl/registro_desplazable.sv
// ----------------------------------------------------------------------------
// registro_desplazable
//   Universal WIDTH-bit shift register: parallel load, serial shift, rotate
//   and hold, in either direction. Serial data enters on S_IN; the bit pushed
//   out by a shift appears on S_OUT. This level only holds the flops and the
//   rst/ENB gating; the operation itself lives in regdesp_next.
//
// Ports
//   clk    in   1      clock, all updates on posedge
//   rst    in   1      synchronous active-high reset (priority over all)
//   ENB    in   1      enable; 0 holds Q and S_OUT
//   DIR    in   1      0 = left (toward MSB), 1 = right (toward LSB)
//   S_IN   in   1      serial input bit
//   MODO   in   2      00 shift, 01 rotate, 10 load, 11 hold
//   D      in   WIDTH  parallel load data
//   Q      out  WIDTH  register contents (registered)
//   S_OUT  out  1      serial output bit (registered)
// ----------------------------------------------------------------------------
module registro_desplazable
    import regdesp_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ENB,
    input  logic             DIR,
    input  logic             S_IN,
    input  logic [1:0]       MODO,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             S_OUT
);

    logic [WIDTH-1:0] q_r;
    logic             s_out_r;
    logic [WIDTH-1:0] q_next;
    logic             s_out_next;

    regdesp_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .q          (q_r),
        .s_out      (s_out_r),
        .d          (D),
        .s_in       (S_IN),
        .dir        (DIR),
        .modo       (MODO),
        .q_next     (q_next),
        .s_out_next (s_out_next)
    );

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the values
        // from before this edge, independent of statement order.
        if (rst) begin
            q_r     <= '0;
            s_out_r <= 1'b0;
        end else if (ENB) begin
            q_r     <= q_next;
            s_out_r <= s_out_next;
        end
    end

    assign Q     = q_r;
    assign S_OUT = s_out_r;

endmodule : registro_desplazable

// File: tb/tb_registro_desplazable.sv
// ----------------------------------------------------------------------------
// tb_registro_desplazable
//   Directed-vector bench for registro_desplazable (WIDTH = 4). Inputs change
//   on the falling edge; outputs are sampled 1 time unit after the rising edge.
// ----------------------------------------------------------------------------
module tb_registro_desplazable;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             ENB;
    logic             DIR;
    logic             S_IN;
    logic [1:0]       MODO;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic             S_OUT;

    int n_checks = 0;
    int n_errors = 0;

    registro_desplazable #(
        .WIDTH (WIDTH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .ENB   (ENB),
        .DIR   (DIR),
        .S_IN  (S_IN),
        .MODO  (MODO),
        .D     (D),
        .Q     (Q),
        .S_OUT (S_OUT)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Apply one set of inputs for exactly one rising edge.
    task automatic step(input logic r, input logic e, input logic dir,
                        input logic sin, input logic [1:0] m, input logic [3:0] d);
        @(negedge clk);
        rst  = r;
        ENB  = e;
        DIR  = dir;
        S_IN = sin;
        MODO = m;
        D    = d;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] d);
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'b10, d);
    endtask

    initial begin
        rst = 1'b1; ENB = 1'b0; DIR = 1'b0; S_IN = 1'b0; MODO = 2'b11; D = '0;

        // Reset priority over an enabled load
        load(4'b1010);
        check("pre_reset_load", {4'b0, Q}, 8'b1010);
        step(1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 4'b1111);
        check("reset_q", {4'b0, Q}, 8'b0000);
        check("reset_sout", {7'b0, S_OUT}, 8'b0);

        // Load then left shift with S_IN=1
        load(4'b0000);
        check("load_zero", {4'b0, Q}, 8'b0000);
        step(1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 4'b0000);
        check("shl_1_q", {4'b0, Q}, 8'b0001);
        check("shl_1_sout", {7'b0, S_OUT}, 8'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 4'b0000);
        check("shl_5_q", {4'b0, Q}, 8'b1111);
        check("shl_5_sout", {7'b0, S_OUT}, 8'b1);

        // Rotate clears S_OUT even when it was 1
        step(1'b0, 1'b1, 1'b1, 1'b1, 2'b01, 4'b0000);
        check("rot_clears_sout_q", {4'b0, Q}, 8'b1111);
        check("rot_clears_sout", {7'b0, S_OUT}, 8'b0);

        // Right shift drain of 1011: S_OUT 1,1,0,1
        load(4'b1011);
        step(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 4'b0000);
        check("shr_sout_1", {7'b0, S_OUT}, 8'b1);
        check("shr_q_1", {4'b0, Q}, 8'b0101);
        step(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 4'b0000);
        check("shr_sout_2", {7'b0, S_OUT}, 8'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 4'b0000);
        check("shr_sout_3", {7'b0, S_OUT}, 8'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 4'b0000);
        check("shr_sout_4", {7'b0, S_OUT}, 8'b1);
        check("shr_final_q", {4'b0, Q}, 8'b0000);

        // Rotate left from 1000; S_IN=1 must be ignored
        load(4'b1000);
        step(1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 4'b0000);
        check("rotl_1_q", {4'b0, Q}, 8'b0001);
        check("rotl_1_sout", {7'b0, S_OUT}, 8'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 4'b0000);
        check("rotl_2_q", {4'b0, Q}, 8'b0010);
        step(1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 4'b0000);
        step(1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 4'b0000);
        check("rotl_4_q", {4'b0, Q}, 8'b1000);
        check("rotl_4_sout", {7'b0, S_OUT}, 8'b0);

        // Rotate right from 0001
        load(4'b0001);
        step(1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 4'b0000);
        check("rotr_1_q", {4'b0, Q}, 8'b1000);
        step(1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 4'b0000);
        check("rotr_2_q", {4'b0, Q}, 8'b0100);

        // Build Q=0110 with S_OUT=1: load 1011, shift left with S_IN=0
        load(4'b1011);
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 4'b0000);
        check("hold_setup_q", {4'b0, Q}, 8'b0110);
        check("hold_setup_sout", {7'b0, S_OUT}, 8'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 4'b0000);
        check("enb0_shift_q", {4'b0, Q}, 8'b0110);
        check("enb0_shift_sout", {7'b0, S_OUT}, 8'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 4'b1001);
        check("enb0_load_q", {4'b0, Q}, 8'b0110);
        check("enb0_load_sout", {7'b0, S_OUT}, 8'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 2'b11, 4'b1001);
        check("modo_hold_q", {4'b0, Q}, 8'b0110);
        check("modo_hold_sout", {7'b0, S_OUT}, 8'b1);

        // Direction change mid-stream from 0001
        load(4'b0001);
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 4'b0000);
        check("dirchg_1_q", {4'b0, Q}, 8'b0010);
        step(1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 4'b0000);
        check("dirchg_2_q", {4'b0, Q}, 8'b1001);
        check("dirchg_2_sout", {7'b0, S_OUT}, 8'b0);

        // Reset while disabled still clears
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 4'b0000);
        check("reset_enb0_q", {4'b0, Q}, 8'b0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_registro_desplazable
